// File: rtl/pcm_linear_interpolator.sv
// pcm_linear_interpolator: resynchronise the PCM word clock and linearly interpolate stereo samples per request
module pcm_linear_interpolator #(
  parameter int PCM_Bit_Length = 32,
  parameter int OSR_LOG2 = 3
) (
  input  logic                             MCLK_I,
  input  logic                             RST_I,
  input  logic                             WCLK_I,
  input  logic signed [PCM_Bit_Length-1:0] DATAL_I,
  input  logic signed [PCM_Bit_Length-1:0] DATAR_I,
  input  logic                             REQ_I,
  output logic signed [PCM_Bit_Length-1:0] DATAL_O,
  output logic signed [PCM_Bit_Length-1:0] DATAR_O,
  output logic                             VALID_O,
  output logic                             UNDER_O,
  output logic                             OVER_O
);
  localparam int W = PCM_Bit_Length;
  localparam int AW = W + 1 + OSR_LOG2;
  localparam logic [OSR_LOG2:0] K_END = {1'b1, {OSR_LOG2{1'b0}}};
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [2:0] r_sync;
  logic [OSR_LOG2:0] r_k;
  logic r_valid, r_under, r_over;
  logic w_new, w_serve, w_end;
  logic signed [W-1:0] w_out [2];
  assign w_new = r_sync[2] & ~r_sync[1];
  assign w_end = r_k == K_END;
  // next state: leave IDLE on the first sample; requests only count while running
  always_comb begin
    w_state_nxt = (r_state == IDLE && w_new) ? RUN : r_state;
    w_serve = REQ_I && r_state == RUN;
  end
  // state register
  always_ff @(posedge MCLK_I or posedge RST_I) begin
    if (RST_I) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // word clock synchroniser, step counter, strobe and sticky error flags
  always_ff @(posedge MCLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_sync <= '0;
      r_k <= '0;
      r_valid <= 1'b0;
      r_under <= 1'b0;
      r_over <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], WCLK_I};
      r_valid <= w_serve;
      if (w_serve && w_end) r_under <= 1'b1;
      if (w_serve && !w_end) r_k <= r_k + 1'b1;
      if (w_new && r_state == RUN && r_k < K_END) r_over <= 1'b1;
      if (w_new) r_k <= '0;
    end
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic signed [W-1:0] w_smp, w_sum, r_prev, r_curr, r_out;
    logic signed [W:0] r_step;
    logic signed [AW-1:0] r_acc;
    assign w_smp = (c == 0) ? DATAL_I : DATAR_I;
    assign w_sum = r_prev + W'(r_acc >>> OSR_LOG2);
    assign w_out[c] = r_out;
    // a request is served from the current ramp; a new sample then reloads it
    always_ff @(posedge MCLK_I or posedge RST_I) begin
      if (RST_I) begin
        r_prev <= '0;
        r_curr <= '0;
        r_step <= '0;
        r_acc <= '0;
        r_out <= '0;
      end else begin
        if (w_serve) r_out <= w_end ? r_curr : w_sum;
        if (w_serve && !w_end) r_acc <= r_acc + AW'(r_step);
        if (w_new) begin
          r_prev <= (r_state == IDLE) ? w_smp : r_curr;
          r_step <= (r_state == IDLE) ? '0 : (W+1)'(w_smp) - (W+1)'(r_curr);
          r_curr <= w_smp;
          r_acc <= '0;
        end
      end
    end
  end
  assign DATAL_O = w_out[0];
  assign DATAR_O = w_out[1];
  assign VALID_O = r_valid;
  assign UNDER_O = r_under;
  assign OVER_O = r_over;
endmodule

// File: tb/tb_pcm_linear_interpolator.sv
// tb_pcm_linear_interpolator: scoreboard bench for the stereo PCM linear interpolator
module tb_pcm_linear_interpolator;
  localparam int W = 32;
  localparam int OSR = 3;
  localparam int N = 1 << OSR;
  logic MCLK_I = 1'b0;
  logic RST_I, WCLK_I, REQ_I;
  logic signed [W-1:0] DATAL_I, DATAR_I, DATAL_O, DATAR_O;
  logic VALID_O, UNDER_O, OVER_O;
  int passed = 0;
  int total = 0;
  logic [2*W-1:0] q[$];
  logic [2*W-1:0] e_exp;
  longint m_prev[2], m_curr[2];
  int m_k;
  bit m_idle, m_under, m_over;
  logic req_seen;

  always #5 MCLK_I = ~MCLK_I;

  pcm_linear_interpolator #(.PCM_Bit_Length(W), .OSR_LOG2(OSR)) dut (
    .MCLK_I(MCLK_I), .RST_I(RST_I), .WCLK_I(WCLK_I), .DATAL_I(DATAL_I), .DATAR_I(DATAR_I),
    .REQ_I(REQ_I), .DATAL_O(DATAL_O), .DATAR_O(DATAR_O), .VALID_O(VALID_O),
    .UNDER_O(UNDER_O), .OVER_O(OVER_O)
  );

  always @(posedge MCLK_I) req_seen <= REQ_I;

  always @(negedge MCLK_I) begin
    if (!RST_I && VALID_O) begin
      total++;
      if (!req_seen || q.size() == 0) begin
        $display("FAIL valid_strobe: got VALID_O=1 (req last edge=%0b, pending=%0d), required no strobe", req_seen, q.size());
      end else begin
        e_exp = q.pop_front();
        if ({DATAL_O, DATAR_O} !== e_exp)
          $display("FAIL sample: got L=%0d R=%0d, required L=%0d R=%0d", DATAL_O, DATAR_O,
                   $signed(e_exp[2*W-1:W]), $signed(e_exp[W-1:0]));
        else passed++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of run, required finish before time limit");
    $fatal(1);
  end

  task automatic m_reset();
    q.delete();
    m_idle = 1;
    m_under = 0;
    m_over = 0;
    m_k = 0;
  endtask

  task automatic m_serve();
    longint e[2];
    if (m_idle) return;
    for (int c = 0; c < 2; c++)
      e[c] = (m_k < N) ? m_prev[c] + ((longint'(m_k) * (m_curr[c] - m_prev[c])) >>> OSR) : m_curr[c];
    if (m_k < N) m_k++;
    else m_under = 1;
    q.push_back({e[0][W-1:0], e[1][W-1:0]});
  endtask

  task automatic m_load(input logic signed [W-1:0] l, input logic signed [W-1:0] r);
    longint s[2];
    s[0] = longint'(l);
    s[1] = longint'(r);
    if (m_idle) begin
      m_prev = s;
      m_curr = s;
      m_idle = 0;
    end else begin
      if (m_k < N) m_over = 1;
      m_prev = m_curr;
      m_curr = s;
    end
    m_k = 0;
  endtask

  task automatic do_reset();
    @(posedge MCLK_I);
    #3 RST_I = 1;
    repeat (2) @(posedge MCLK_I);
    #2 RST_I = 0;
    m_reset();
  endtask

  task automatic send(input logic signed [W-1:0] l, input logic signed [W-1:0] r);
    @(posedge MCLK_I);
    #2 WCLK_I = 1;
    repeat (3) @(posedge MCLK_I);
    #2;
    DATAL_I = l;
    DATAR_I = r;
    WCLK_I = 0;
    m_load(l, r);
    repeat (5) @(posedge MCLK_I);
    #2;
  endtask

  task automatic reqs(input int n, input int gap);
    @(posedge MCLK_I);
    #2;
    for (int i = 0; i < n; i++) begin
      REQ_I = 1;
      m_serve();
      @(posedge MCLK_I);
      #2;
      if (gap > 0) begin
        REQ_I = 0;
        repeat (gap) begin
          @(posedge MCLK_I);
          #2;
        end
      end
    end
    REQ_I = 0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({DATAL_O, DATAR_O, VALID_O, UNDER_O, OVER_O} !== '0)
      $display("FAIL reset_state: got L=%0d R=%0d V=%0b U=%0b O=%0b, required all 0", DATAL_O, DATAR_O, VALID_O, UNDER_O, OVER_O);
    else passed++;
    repeat (2) @(posedge MCLK_I);
    #2 RST_I = 0;
    m_reset();
    send(0, 0);
    reqs(8, 0);
    send(800, -800);
    reqs(3, 0);
    #1 RST_I = 1;
    #1;
    total++;
    if ({DATAL_O, DATAR_O, VALID_O, UNDER_O, OVER_O} !== '0)
      $display("FAIL reset_async: got L=%0d R=%0d V=%0b U=%0b O=%0b, required all 0", DATAL_O, DATAR_O, VALID_O, UNDER_O, OVER_O);
    else passed++;
    @(posedge MCLK_I);
    #2 RST_I = 0;
    m_reset();
    reqs(3, 1);
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if ({DATAL_O, VALID_O, UNDER_O} !== '0)
      $display("FAIL reset_idle_req: got L=%0d V=%0b U=%0b, required 0 0 0", DATAL_O, VALID_O, UNDER_O);
    else passed++;
    send(1000, -1000);
    reqs(1, 0);
    repeat (2) @(posedge MCLK_I);
  endtask

  task automatic test_first_sample();
    do_reset();
    send(1000, -5);
    reqs(8, 1);
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if (UNDER_O !== 1'b0) $display("FAIL first_under_early: got %0b, required 0", UNDER_O);
    else passed++;
    reqs(1, 0);
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if (UNDER_O !== 1'b1) $display("FAIL first_under_set: got %0b, required 1", UNDER_O);
    else passed++;
  endtask

  task automatic test_ramp();
    do_reset();
    send(0, 0);
    reqs(8, 0);
    send(800, -800);
    reqs(9, 0);
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if ({UNDER_O, OVER_O} !== {m_under, m_over})
      $display("FAIL ramp_flags: got U=%0b O=%0b, required U=%0b O=%0b", UNDER_O, OVER_O, m_under, m_over);
    else passed++;
  endtask

  task automatic test_full_scale();
    do_reset();
    send(32'sh7FFFFFFF, 32'sh80000000);
    reqs(8, 0);
    send(32'sh80000000, 32'sh7FFFFFFF);
    reqs(9, 2);
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if (q.size() != 0) $display("FAIL full_scale_drain: got %0d pending, required 0", q.size());
    else passed++;
  endtask

  task automatic test_overrun();
    do_reset();
    send(0, 0);
    reqs(8, 0);
    send(800, -800);
    reqs(3, 0);
    send(1600, 0);
    total++;
    if (OVER_O !== 1'b1) $display("FAIL overrun_flag: got %0b, required 1", OVER_O);
    else passed++;
    reqs(2, 1);
    repeat (2) @(posedge MCLK_I);
  endtask

  task automatic test_collision();
    do_reset();
    send(0, 0);
    reqs(8, 0);
    send(800, -800);
    reqs(4, 0);
    @(posedge MCLK_I);
    #2 WCLK_I = 1;
    repeat (3) @(posedge MCLK_I);
    #2;
    DATAL_I = 1600;
    DATAR_I = 100;
    WCLK_I = 0;
    repeat (2) @(posedge MCLK_I);
    #2 REQ_I = 1;
    m_serve();
    m_load(1600, 100);
    @(posedge MCLK_I);
    #2 REQ_I = 0;
    reqs(2, 0);
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if (OVER_O !== 1'b1) $display("FAIL collision_over: got %0b, required 1", OVER_O);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send($urandom, $urandom);
      reqs(8, $urandom_range(0, 2));
    end
    repeat (2) @(posedge MCLK_I);
    #2;
    total++;
    if ({UNDER_O, OVER_O, 32'(q.size())} !== {m_under, m_over, 32'd0})
      $display("FAIL random_end: got U=%0b O=%0b pending=%0d, required U=%0b O=%0b pending=0", UNDER_O, OVER_O, q.size(), m_under, m_over);
    else passed++;
  endtask

  initial begin
    RST_I = 1;
    WCLK_I = 0;
    REQ_I = 0;
    DATAL_I = '0;
    DATAR_I = '0;
    m_reset();
    test_reset();
    test_first_sample();
    test_ramp();
    test_full_scale();
    test_overrun();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
